upcoin: RTL and testbench

SPI-attached SHA-256 accelerator for the MicroPCoin miner. A host shifts in a pre-padded 512-bit message block over a three-wire serial link. The block runs the 64-round SHA-256 compression on that block and raises `done`. The host then clocks the 256-bit digest back out, MSB first. Multi-block messages are supported by chaining the intermediate hash across consecutive blocks.

---
 rtl/upcoin.sv | 218 +++++++++++++++++++++
 tb/tb_upcoin.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/upcoin.sv
// upcoin: SHA-256 compression engine behind a three-wire serial link.
//
// The host shifts a padded 512-bit block in on sck while block_load is high. The falling
// edge of block_load (seen through a synchronizer) starts 64 rounds of compression on clk.
// The digest is then read back MSB first on sdo, advancing on each sck fall.
//
// Ports:
//   clk          in  core clock; the hash core and FSM run on its rising edge
//   reset        in  synchronous active-high reset (clk domain)
//   sck          in  host shift clock; only the serial shifter and output counter use it
//   sdi          in  serial data in, sampled on sck rise while block_load = 1
//   sdo          out digest bit selected by the output counter, 0 when done = 0
//   block_load   in  high while a block is shifted in; falling edge starts hashing
//   message_load in  high while loading the first block of a message (selects IV)
//   done         out high while a valid digest is available
module upcoin (
   input  logic clk,
   input  logic reset,
   input  logic sck,
   input  logic sdi,
   output logic sdo,
   input  logic block_load,
   input  logic message_load,
   output logic done
);

   typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_e;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // ---------------------------------------------------------------- sck domain
   logic [511:0] r_msg;
   logic [7:0]   r_outcnt;

   always_ff @(posedge sck) begin
      if (block_load) begin
         r_msg <= {r_msg[510:0], sdi};
      end
   end

   // Advancing on the fall keeps sdo stable across the host's sample after the rise.
   always_ff @(negedge sck) begin
      if (block_load) begin
         r_outcnt <= 8'd0;
      end else if (done && (r_outcnt != 8'd255)) begin
         r_outcnt <= r_outcnt + 8'd1;
      end
   end

   // ---------------------------------------------------------------- clk domain
   state_e        r_state, w_state_next;
   logic [1:0]    r_bl_sync, r_ml_sync;
   logic          r_bl_prev;
   logic          r_ml_hold;
   logic          r_first;
   logic [31:0]   r_h [8];
   logic [31:0]   r_v [8];
   logic [31:0]   r_w [16];
   logic [5:0]    r_t;
   logic [255:0]  r_digest;

   logic          w_bl_rise, w_bl_fall;
   logic [31:0]   w_hbase [8];
   logic [31:0]   w_hsum  [8];
   logic [31:0]   w_t1, w_t2, w_wnew;

   assign w_bl_rise = r_bl_sync[1] & ~r_bl_prev;
   assign w_bl_fall = ~r_bl_sync[1] & r_bl_prev;

   assign done = (r_state == StDone);
   assign sdo  = done & r_digest[8'd255 - r_outcnt];

   // H is never overwritten by the IV; the IV is muxed in instead so an aborted first
   // block leaves the chained hash untouched.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_hbase[i] = r_first ? IV[i] : r_h[i];
         w_hsum[i]  = w_hbase[i] + r_v[i];
      end
   end

   always_comb begin
      w_t1 = r_v[7] + big_sigma1(r_v[4]) + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]))
             + K[r_t] + r_w[0];
      w_t2 = big_sigma0(r_v[0]) + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
      // r_w[j] holds W[t+j]; this is W[t+16].
      w_wnew = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_bl_fall) w_state_next = StInit;
         StInit:  w_state_next = w_bl_rise ? StIdle : StRound;
         StRound: begin
            if (w_bl_rise) begin
               w_state_next = StIdle;
            end else if (r_t == 6'd63) begin
               w_state_next = StFinal;
            end
         end
         StFinal: w_state_next = w_bl_rise ? StIdle : StDone;
         StDone:  if (w_bl_rise) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bl_sync <= 2'b00;
         r_ml_sync <= 2'b00;
         r_bl_prev <= 1'b0;
         r_ml_hold <= 1'b1;
         r_first   <= 1'b1;
         r_digest  <= '0;
         for (int i = 0; i < 8; i++) begin
            r_h[i] <= IV[i];
         end
      end else begin
         r_bl_sync <= {r_bl_sync[0], block_load};
         r_ml_sync <= {r_ml_sync[0], message_load};
         r_bl_prev <= r_bl_sync[1];
         // Track message_load only while block_load is seen high, so a simultaneous
         // drop of both pins still latches the value that belonged to the block.
         if (r_bl_sync[1]) begin
            r_ml_hold <= r_ml_sync[1];
         end
         if ((r_state == StIdle) && w_bl_fall) begin
            r_first <= r_ml_hold;
         end
         if ((r_state == StFinal) && !w_bl_rise) begin
            for (int i = 0; i < 8; i++) begin
               r_h[i] <= w_hsum[i];
            end
            r_digest <= {w_hsum[0], w_hsum[1], w_hsum[2], w_hsum[3],
                         w_hsum[4], w_hsum[5], w_hsum[6], w_hsum[7]};
         end
      end
   end

   // Working variables and schedule window need no reset: INIT always reloads them.
   always_ff @(posedge clk) begin
      if (r_state == StInit) begin
         for (int i = 0; i < 8; i++) begin
            r_v[i] <= w_hbase[i];
         end
         for (int i = 0; i < 16; i++) begin
            r_w[i] <= r_msg[511 - 32*i -: 32];
         end
         r_t <= 6'd0;
      end else if (r_state == StRound) begin
         r_v[0] <= w_t1 + w_t2;
         r_v[1] <= r_v[0];
         r_v[2] <= r_v[1];
         r_v[3] <= r_v[2];
         r_v[4] <= r_v[3] + w_t1;
         r_v[5] <= r_v[4];
         r_v[6] <= r_v[5];
         r_v[7] <= r_v[6];
         for (int i = 0; i < 15; i++) begin
            r_w[i] <= r_w[i+1];
         end
         r_w[15] <= w_wnew;
         r_t     <= r_t + 6'd1;
      end
   end

endmodule

// File: tb/tb_upcoin.sv
// Bench for upcoin: loads known SHA-256 blocks over the serial link, queues the expected
// digest when a block is loaded and compares it when the digest is read back.
module tb_upcoin;

   logic clk = 1'b0;
   logic reset, sck, sdi, sdo, block_load, message_load, done;

   int n_checks = 0;
   int n_errors = 0;
   logic [255:0] sb_q [$];

   logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2;
   logic [255:0] dig_abc, dig_empty, dig_two, got, unused;
   int           lat;

   upcoin u_dut (
      .clk          (clk),
      .reset        (reset),
      .sck          (sck),
      .sdi          (sdi),
      .sdo          (sdo),
      .block_load   (block_load),
      .message_load (message_load),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got_v, input logic [255:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   // Shift a block in; optionally queue the digest it should produce.
   task automatic load_block(input logic [511:0] blk, input logic ml, input logic push,
                             input logic [255:0] exp_v);
      @(negedge clk);
      block_load   = 1'b1;
      message_load = ml;
      repeat (4) @(negedge clk);
      check("done_clr", {255'd0, done}, 256'd0);
      for (int i = 511; i >= 0; i--) begin
         sdi = blk[i];
         #1 sck = 1'b1;
         #3 sck = 1'b0;
         #2;
      end
      @(negedge clk);
      #1;
      block_load   = 1'b0;
      message_load = 1'b0;
      if (push) sb_q.push_back(exp_v);
   endtask

   // Count clk cycles from the block_load fall until done, bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      check("lat_lo", {255'd0, (n >= 66)}, 256'd1);
      check("lat_hi", {255'd0, (n <= 70)}, 256'd1);
   endtask

   task automatic read_bits(input int nbits, output logic [255:0] d);
      d = '0;
      for (int i = 0; i < nbits; i++) begin
         sck = 1'b1;
         #2 d[255-i] = sdo;
         #2 sck = 1'b0;
         #2;
      end
   endtask

   task automatic read_full();
      logic [255:0] d, e;
      read_bits(256, d);
      if (sb_q.size() == 0) begin
         check("sb_empty", 256'd1, 256'd0);
      end else begin
         e = sb_q.pop_front();
         check("digest", d, e);
         // An extra pulse keeps presenting bit 0.
         sck = 1'b1;
         #2 check("hold_b0", {255'd0, sdo}, {255'd0, e[0]});
         #2 sck = 1'b0;
         #2;
      end
      check("done_hold", {255'd0, done}, 256'd1);
   endtask

   initial begin
      blk_abc   = {32'h61626380, 448'd0, 32'h00000018};
      blk_empty = {32'h80000000, 480'd0};
      blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      blk_two2  = {448'd0, 32'h00000000, 32'h000001c0};
      dig_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
      dig_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
      dig_two   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
      unused    = '0;

      reset = 1'b1; sck = 1'b0; sdi = 1'b0; block_load = 1'b0; message_load = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_done", {255'd0, done}, 256'd0);
      check("rst_sdo", {255'd0, sdo}, 256'd0);

      // Single block "abc".
      load_block(blk_abc, 1'b1, 1'b1, dig_abc);
      wait_done(lat);
      read_full();

      // Empty string.
      load_block(blk_empty, 1'b1, 1'b1, dig_empty);
      wait_done(lat);
      read_full();

      // Two-block message with chaining.
      load_block(blk_two1, 1'b1, 1'b0, unused);
      wait_done(lat);
      load_block(blk_two2, 1'b0, 1'b1, dig_two);
      wait_done(lat);
      read_full();

      // Reset while a digest is presented.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_in_done", {255'd0, done}, 256'd0);
      check("rst_in_sdo", {255'd0, sdo}, 256'd0);

      // Reset about 20 rounds into a hash, then make sure it never completes.
      load_block(blk_abc, 1'b1, 1'b0, unused);
      repeat (24) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_done", {255'd0, done}, 256'd0);
      check("rst_mid_sdo", {255'd0, sdo}, 256'd0);
      repeat (100) @(negedge clk);
      check("no_resume", {255'd0, done}, 256'd0);

      // Clean reload after the aborted hash.
      load_block(blk_abc, 1'b1, 1'b1, dig_abc);
      wait_done(lat);
      read_full();

      // Partial readout, then restart with a new block.
      load_block(blk_abc, 1'b1, 1'b0, unused);
      wait_done(lat);
      read_bits(128, got);
      check("half_read", {128'd0, got[255:128]}, {128'd0, dig_abc[255:128]});
      load_block(blk_abc, 1'b1, 1'b1, dig_abc);
      wait_done(lat);
      read_full();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
